spell_sequencer: RTL and testbench
==================================

Name: spell_sequencer

Overview:
Multi-cycle control stage directly upstream of spell_execute. It owns the architectural state: pc, sp, the 32x8 data stack and the opcode register. It fetches opcodes over a shared memory bus and pre-loads memory_input for read opcodes. It drives spell_execute combinationally, then commits its results (stack writes, pc/sp update, memory write, delay, sleep).

Parameters:
DELAY_UNIT_CYCLES, 16, clock cycles per unit of delay_amount (must be >= 1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  level; 1 allows fetch of the next opcode
wake  input  1  pulse; leaves SLEEP
mem_req  output  1  bus request, held until ack
mem_we  output  1  1=write, 0=read
mem_space  output  2  0=code, 1=data, 2=io
mem_addr  output  8  bus address
mem_wdata  output  8  write data
mem_rdata  input  8  read data, valid when mem_ack=1
mem_ack  input  1  one-cycle completion strobe
ex_opcode  output  8  to spell_execute opcode
ex_pc  output  8  to pc
ex_sp  output  5  to sp
ex_stack_top  output  8  stack[sp-1]
ex_stack_belowtop  output  8  stack[sp-2]
ex_memory_input  output  8  loaded operand register
ex_out_of_order_exec  output  1  constant 0
ex_next_pc  input  8  from spell_execute
ex_next_sp  input  5
ex_stack_write_count  input  2
ex_set_stack_top  input  8
ex_set_stack_belowtop  input  8
ex_memory_write_type  input  2  0=none, 1=data, 2=io, 3=treated as none
ex_memory_write_addr  input  8
ex_memory_write_data  input  8
ex_delay_amount  input  8
ex_sleep  input  1
state  output  3  current FSM state (debug)
busy  output  1  1 in any state except IDLE and SLEEP

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, sp=0, opcode=0, memory_input=0, delay counter=0, mem_req=0, mem_we=0, mem_space=0, mem_addr=0, mem_wdata=0. Stack contents are not reset.
- States:
  - IDLE(0): if run=1, go to FETCH.
  - FETCH(1): mem_req=1, we=0, space=code, addr=pc. On mem_ack, opcode<=mem_rdata; go to LOAD if the opcode is "?" or "r", else EXECUTE.
  - LOAD(2): read at addr=stack_top, space=data for "?" and io for "r". On ack, memory_input<=mem_rdata; go to EXECUTE.
  - EXECUTE(3): exactly 1 cycle, spell_execute outputs sampled.
    - pc<=next_pc, sp<=next_sp.
    - write_count>=1: stack[next_sp-1]<=set_stack_top. write_count=2: also stack[next_sp-2]<=set_stack_belowtop. write_count=3 behaves as 2.
    - Next state priority: STORE if write_type in {1,2}; else DELAY if delay_amount!=0; else SLEEP if sleep; else FETCH if run; else IDLE.
    - Write address, data, type, delay_amount and sleep are latched at EXECUTE.
  - STORE(4): mem_req=1, we=1, space from latched type, addr/wdata latched. On ack, continue with the same priority chain minus STORE.
  - DELAY(5): counter loaded with delay_amount*DELAY_UNIT_CYCLES (16-bit), decremented every cycle. At 1, go to SLEEP if latched sleep, else FETCH/IDLE per run.
  - SLEEP(6): wait for wake=1, then go to IDLE.
- Bus: mem_req rises on state entry and drops the cycle after mem_ack. Address, space, we and wdata are stable while req=1. ack while req=0 is ignored. Ack may arrive the first cycle req is high, giving a 1-cycle access.
- Index arithmetic is 5-bit modulo 32: sp=0 gives stack_top=stack[31] and belowtop=stack[30]. pc is 8-bit and wraps 255 to 0.
- run is sampled only in IDLE and at instruction end. Deasserting run mid-instruction completes the instruction.
- A reset during a bus transaction drops mem_req asynchronously. No commit occurs.
- Minimum instruction time: FETCH(1 with immediate ack) + EXECUTE(1) = 2 cycles.

Decomposition:
- Package spell_pkg holds state encodings (STATE_IDLE..STATE_SLEEP), mem_space codes (SPACE_CODE/DATA/IO), and memory_write_type codes (MEMW_NONE/DATA/IO).
- One sub-module, spell_stack: 32x8 register file with two async read ports (sp-1, sp-2) and two sync write ports (top, belowtop). No reset.
- spell_execute is instantiated beside this block at top level, not inside it.

Test Plan:
- Setup: a bench memory model acks after 1 cycle and holds code "+" at 0 with stack {15,10}, sp=2. Raise run -> ex_opcode=0x2B in EXECUTE; a stubbed execute returning next_sp=1, set_stack_top=25 gives stack[0]=25, sp=1, pc=1.
- Read op: code "?" at pc 0, stack_top=0x10, data[0x10]=0x42 -> LOAD issues space=1, addr=0x10; ex_memory_input=0x42 during EXECUTE.
- Write op: execute returns write_type=2, addr=0x07, data=0xA5 -> STORE with we=1, space=2, addr=0x07, wdata=0xA5. Ack delayed 3 cycles -> req held 3 cycles, then FETCH of pc+1.
- Delay plus sleep: delay_amount=2, sleep=1, DELAY_UNIT_CYCLES=4 -> exactly 8 cycles in DELAY, then SLEEP with busy=0. wake pulse -> IDLE, then FETCH if run=1.
- Wrap: sp=0, write_count=2, next_sp=0 -> stack[31]=top, stack[30]=belowtop. pc=255 with next_pc=0 fetches addr 0.
- Reset mid-FETCH: assert reset while mem_req=1 -> mem_req=0 and state=IDLE in the same cycle. After release with run=1, fetch from pc=0.

Source files
------------

// File: rtl/spell_pkg.sv
// rtl/spell_pkg.sv - shared encodings for the spell sequencer
package spell_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE    = 3'd0,
        STATE_FETCH   = 3'd1,
        STATE_LOAD    = 3'd2,
        STATE_EXECUTE = 3'd3,
        STATE_STORE   = 3'd4,
        STATE_DELAY   = 3'd5,
        STATE_SLEEP   = 3'd6
    } state_t;

    localparam logic [1:0] SPACE_CODE = 2'd0;
    localparam logic [1:0] SPACE_DATA = 2'd1;
    localparam logic [1:0] SPACE_IO   = 2'd2;

    localparam logic [1:0] MEMW_NONE = 2'd0;
    localparam logic [1:0] MEMW_DATA = 2'd1;
    localparam logic [1:0] MEMW_IO   = 2'd2;

    localparam logic [7:0] OP_READ_DATA = 8'h3F;  // "?"
    localparam logic [7:0] OP_READ_IO   = 8'h72;  // "r"

    function automatic logic is_read_op(input logic [7:0] op);
        return (op == OP_READ_DATA) || (op == OP_READ_IO);
    endfunction

endpackage

// File: rtl/spell_stack.sv
// rtl/spell_stack.sv - 32x8 data stack, two async reads below sp, two sync writes
module spell_stack (
    input  logic       clock,
    input  logic [4:0] read_sp,
    output logic [7:0] top,
    output logic [7:0] belowtop,
    input  logic [4:0] write_sp,
    input  logic       write_top,
    input  logic       write_belowtop,
    input  logic [7:0] top_data,
    input  logic [7:0] belowtop_data
);

    logic [7:0] mem [32];

    // 5-bit index arithmetic wraps, so sp=0 addresses entries 31 and 30
    assign top      = mem[read_sp - 5'd1];
    assign belowtop = mem[read_sp - 5'd2];

    always_ff @(posedge clock) begin
        if (write_top) begin
            mem[write_sp - 5'd1] <= top_data;
        end
        if (write_belowtop) begin
            mem[write_sp - 5'd2] <= belowtop_data;
        end
    end

endmodule

// File: rtl/spell_sequencer.sv
// rtl/spell_sequencer.sv - multi-cycle fetch/load/commit control stage for spell_execute
module spell_sequencer
    import spell_pkg::*;
#(
    parameter int DELAY_UNIT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       wake,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_space,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] ex_opcode,
    output logic [7:0] ex_pc,
    output logic [4:0] ex_sp,
    output logic [7:0] ex_stack_top,
    output logic [7:0] ex_stack_belowtop,
    output logic [7:0] ex_memory_input,
    output logic       ex_out_of_order_exec,
    input  logic [7:0] ex_next_pc,
    input  logic [4:0] ex_next_sp,
    input  logic [1:0] ex_stack_write_count,
    input  logic [7:0] ex_set_stack_top,
    input  logic [7:0] ex_set_stack_belowtop,
    input  logic [1:0] ex_memory_write_type,
    input  logic [7:0] ex_memory_write_addr,
    input  logic [7:0] ex_memory_write_data,
    input  logic [7:0] ex_delay_amount,
    input  logic       ex_sleep,
    output logic [2:0] state,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [7:0]  pc, opcode, memory_input;
    logic [4:0]  sp;
    logic [15:0] delay_count;
    logic [1:0]  w_type;
    logic [7:0]  w_addr, w_data;
    logic        delay_pending, sleep_pending;
    logic        in_execute;

    assign in_execute = (state_q == STATE_EXECUTE);

    spell_stack u_stack (
        .clock          (clock),
        .read_sp        (sp),
        .top            (ex_stack_top),
        .belowtop       (ex_stack_belowtop),
        .write_sp       (ex_next_sp),
        .write_top      (in_execute && (ex_stack_write_count != 2'd0)),
        .write_belowtop (in_execute && ex_stack_write_count[1]),
        .top_data       (ex_set_stack_top),
        .belowtop_data  (ex_set_stack_belowtop)
    );

    // Shared instruction tail once any memory write is done
    function automatic state_t tail_state(input logic delay_nz, input logic sleep_req,
                                          input logic run_req);
        if (delay_nz)       return STATE_DELAY;
        else if (sleep_req) return STATE_SLEEP;
        else if (run_req)   return STATE_FETCH;
        else                return STATE_IDLE;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_space = SPACE_CODE;
        mem_addr  = pc;
        case (state_q)
            STATE_IDLE: begin
                if (run) state_d = STATE_FETCH;
            end
            STATE_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = is_read_op(mem_rdata) ? STATE_LOAD : STATE_EXECUTE;
            end
            STATE_LOAD: begin
                mem_req   = 1'b1;
                mem_space = (opcode == OP_READ_DATA) ? SPACE_DATA : SPACE_IO;
                mem_addr  = ex_stack_top;
                if (mem_ack) state_d = STATE_EXECUTE;
            end
            STATE_EXECUTE: begin
                if (ex_memory_write_type == MEMW_DATA || ex_memory_write_type == MEMW_IO)
                    state_d = STATE_STORE;
                else
                    state_d = tail_state(ex_delay_amount != 8'd0, ex_sleep, run);
            end
            STATE_STORE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_space = (w_type == MEMW_IO) ? SPACE_IO : SPACE_DATA;
                mem_addr  = w_addr;
                if (mem_ack) state_d = tail_state(delay_pending, sleep_pending, run);
            end
            STATE_DELAY: begin
                // <= 1 also guards against a zero count from product overflow
                if (delay_count <= 16'd1)
                    state_d = tail_state(1'b0, sleep_pending, run);
            end
            STATE_SLEEP: begin
                if (wake) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc            <= 8'd0;
            sp            <= 5'd0;
            opcode        <= 8'd0;
            memory_input  <= 8'd0;
            delay_count   <= 16'd0;
            w_type        <= MEMW_NONE;
            w_addr        <= 8'd0;
            w_data        <= 8'd0;
            delay_pending <= 1'b0;
            sleep_pending <= 1'b0;
        end else begin
            case (state_q)
                STATE_FETCH: if (mem_ack) opcode <= mem_rdata;
                STATE_LOAD:  if (mem_ack) memory_input <= mem_rdata;
                STATE_EXECUTE: begin
                    pc            <= ex_next_pc;
                    sp            <= ex_next_sp;
                    w_type        <= ex_memory_write_type;
                    w_addr        <= ex_memory_write_addr;
                    w_data        <= ex_memory_write_data;
                    delay_pending <= (ex_delay_amount != 8'd0);
                    sleep_pending <= ex_sleep;
                    delay_count   <= 16'(ex_delay_amount) * 16'(DELAY_UNIT_CYCLES);
                end
                STATE_DELAY: delay_count <= delay_count - 16'd1;
                default: ;
            endcase
        end
    end

    assign mem_wdata            = w_data;
    assign ex_opcode            = opcode;
    assign ex_pc                = pc;
    assign ex_sp                = sp;
    assign ex_memory_input      = memory_input;
    assign ex_out_of_order_exec = 1'b0;
    assign state                = state_q;
    assign busy                 = (state_q != STATE_IDLE) && (state_q != STATE_SLEEP);

endmodule

// File: tb/tb_spell_sequencer.sv
// tb/tb_spell_sequencer.sv - bench for spell_sequencer with stubbed execute and bus memory
module tb_spell_sequencer;
    import spell_pkg::*;

    localparam int UNIT = 4;

    logic       clock = 1'b0, reset = 1'b1, run = 1'b0, wake = 1'b0;
    logic       mem_req, mem_we, mem_ack = 1'b0;
    logic [1:0] mem_space;
    logic [7:0] mem_addr, mem_wdata, mem_rdata = 8'd0;
    logic [7:0] ex_opcode, ex_pc, ex_stack_top, ex_stack_belowtop, ex_memory_input;
    logic [4:0] ex_sp;
    logic       ex_out_of_order_exec;
    logic [7:0] ex_next_pc = 0, ex_set_stack_top = 0, ex_set_stack_belowtop = 0;
    logic [4:0] ex_next_sp = 0;
    logic [1:0] ex_stack_write_count = 0, ex_memory_write_type = 0;
    logic [7:0] ex_memory_write_addr = 0, ex_memory_write_data = 0, ex_delay_amount = 0;
    logic       ex_sleep = 0;
    logic [2:0] state;
    logic       busy;

    logic [7:0] code_mem [256];
    logic [7:0] data_mem [256];
    logic [7:0] io_mem   [256];
    int         ack_lat = 0, wcnt = 0;
    logic       was_ack;
    logic [1:0] log_space = 0;
    logic [7:0] log_addr = 0, log_data = 0;

    logic [7:0] m_stack [32];
    bit         m_valid [32];
    logic [7:0] m_pc = 0;
    logic [4:0] m_sp = 0;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    spell_sequencer #(.DELAY_UNIT_CYCLES(UNIT)) dut (
        .clock(clock), .reset(reset), .run(run), .wake(wake),
        .mem_req(mem_req), .mem_we(mem_we), .mem_space(mem_space), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_sp(ex_sp), .ex_stack_top(ex_stack_top),
        .ex_stack_belowtop(ex_stack_belowtop), .ex_memory_input(ex_memory_input),
        .ex_out_of_order_exec(ex_out_of_order_exec), .ex_next_pc(ex_next_pc),
        .ex_next_sp(ex_next_sp), .ex_stack_write_count(ex_stack_write_count),
        .ex_set_stack_top(ex_set_stack_top), .ex_set_stack_belowtop(ex_set_stack_belowtop),
        .ex_memory_write_type(ex_memory_write_type), .ex_memory_write_addr(ex_memory_write_addr),
        .ex_memory_write_data(ex_memory_write_data), .ex_delay_amount(ex_delay_amount),
        .ex_sleep(ex_sleep), .state(state), .busy(busy)
    );

    always #5 clock = ~clock;

    // Bus responder: acks ack_lat cycles after req rises; each ack ends a transaction
    always @(negedge clock) begin
        was_ack = mem_ack;
        mem_ack = 1'b0;
        if (!mem_req || was_ack) wcnt = 0;
        if (mem_req) begin
            if (wcnt >= ack_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    log_space = mem_space;
                    log_addr  = mem_addr;
                    log_data  = mem_wdata;
                    if (mem_space == SPACE_DATA) data_mem[mem_addr] = mem_wdata;
                    else if (mem_space == SPACE_IO) io_mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = (mem_space == SPACE_CODE) ? code_mem[mem_addr] :
                                (mem_space == SPACE_DATA) ? data_mem[mem_addr] : io_mem[mem_addr];
                end
            end else begin
                wcnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_instr(input logic [7:0] npc, input logic [4:0] nsp, input logic [1:0] wc,
                            input logic [7:0] top, input logic [7:0] below,
                            input logic [1:0] wt, input logic [7:0] wa, input logic [7:0] wd,
                            input logic [7:0] dl, input logic sl, input int lat,
                            input logic keep_run);
        int         n;
        logic       seen_load;
        logic [1:0] ld_space;
        logic [7:0] ld_addr, op, tv;
        ex_next_pc = npc; ex_next_sp = nsp; ex_stack_write_count = wc;
        ex_set_stack_top = top; ex_set_stack_belowtop = below;
        ex_memory_write_type = wt; ex_memory_write_addr = wa; ex_memory_write_data = wd;
        ex_delay_amount = dl; ex_sleep = sl; ack_lat = lat; run = 1'b1;
        seen_load = 1'b0; ld_space = 0; ld_addr = 0; n = 0;
        do begin
            @(negedge clock);
            n++;
            if (state == STATE_LOAD && !seen_load) begin
                seen_load = 1'b1; ld_space = mem_space; ld_addr = mem_addr;
            end
        end while (state != STATE_EXECUTE && n < 100);
        check("exec_reached", state, STATE_EXECUTE);
        op = code_mem[m_pc];
        check("opcode", ex_opcode, op);
        check("pc", ex_pc, m_pc);
        check("sp", ex_sp, m_sp);
        check("exec_busy", busy, 1'b1);
        check("ooo_exec", ex_out_of_order_exec, 1'b0);
        if (m_valid[m_sp - 5'd1]) check("stack_top", ex_stack_top, m_stack[m_sp - 5'd1]);
        if (m_valid[m_sp - 5'd2]) check("stack_below", ex_stack_belowtop, m_stack[m_sp - 5'd2]);
        if (op == 8'h3F || op == 8'h72) begin
            check("load_seen", seen_load, 1'b1);
            check("load_space", ld_space, (op == 8'h3F) ? 2'd1 : 2'd2);
            if (m_valid[m_sp - 5'd1]) begin
                tv = m_stack[m_sp - 5'd1];
                check("load_addr", ld_addr, tv);
                check("mem_input", ex_memory_input, (op == 8'h3F) ? data_mem[tv] : io_mem[tv]);
            end
        end
        run = keep_run;
        m_pc = npc;
        m_sp = nsp;
        if (wc != 2'd0) begin m_stack[nsp - 5'd1] = top;   m_valid[nsp - 5'd1] = 1'b1; end
        if (wc >= 2'd2) begin m_stack[nsp - 5'd2] = below; m_valid[nsp - 5'd2] = 1'b1; end
        @(negedge clock);
        if (wt == 2'd1 || wt == 2'd2) begin
            check("store_state", state, STATE_STORE);
            check("store_req", mem_req, 1'b1);
            check("store_we", mem_we, 1'b1);
            check("store_space", mem_space, wt);
            check("store_addr", mem_addr, wa);
            check("store_wdata", mem_wdata, wd);
            n = 0;
            while (state == STATE_STORE && n < 50) begin n++; @(negedge clock); end
            check("store_cycles", n, lat + 1);
            check("store_log", {log_space, log_addr, log_data}, {wt, wa, wd});
        end
        if (dl != 8'd0) begin
            check("delay_state", state, STATE_DELAY);
            n = 0;
            while (state == STATE_DELAY && n < 3000) begin n++; @(negedge clock); end
            check("delay_cycles", n, int'(dl) * UNIT);
        end
        if (sl) begin
            check("sleep_state", state, STATE_SLEEP);
            check("sleep_busy", busy, 1'b0);
            @(negedge clock);
            check("sleep_hold", state, STATE_SLEEP);
            wake = 1'b1;
            @(negedge clock);
            wake = 1'b0;
            check("wake_idle", state, STATE_IDLE);
            @(negedge clock);
        end
        if (keep_run) begin
            check("next_fetch", state, STATE_FETCH);
            check("fetch_addr", mem_addr, m_pc);
            check("fetch_space", mem_space, SPACE_CODE);
        end else begin
            check("end_idle", state, STATE_IDLE);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            code_mem[i] = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 8'h3F : 8'h72)
                                                    : 8'($urandom);
            data_mem[i] = 8'($urandom);
            io_mem[i]   = 8'($urandom);
        end
        code_mem[0] = 8'h6E; code_mem[1] = 8'h2B; code_mem[2] = 8'h50; code_mem[3] = 8'h3F;
        code_mem[4] = 8'h21; code_mem[5] = 8'h00; code_mem[6] = 8'h00; code_mem[255] = 8'h00;
        data_mem[8'h10] = 8'h42;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_state", state, STATE_IDLE);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_space", mem_space, 2'd0);
        check("rst_addr", mem_addr, 8'd0);
        check("rst_wdata", mem_wdata, 8'd0);
        check("rst_pc", ex_pc, 8'd0);
        check("rst_sp", ex_sp, 5'd0);
        check("rst_opcode", ex_opcode, 8'd0);
        check("rst_minput", ex_memory_input, 8'd0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_no_run", state, STATE_IDLE);

        do_instr(8'd1, 5'd2, 2'd2, 8'd10, 8'd15, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b1);
        do_instr(8'd2, 5'd1, 2'd1, 8'd25, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b1);
        do_instr(8'd3, 5'd2, 2'd1, 8'h10, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b1);
        do_instr(8'd4, 5'd2, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b1);
        do_instr(8'd5, 5'd2, 2'd0, 8'd0, 8'd0, 2'd2, 8'h07, 8'hA5, 8'd0, 1'b0, 2, 1'b1);
        do_instr(8'd6, 5'd2, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 8'd2, 1'b1, 0, 1'b1);
        do_instr(8'd255, 5'd0, 2'd2, 8'hAA, 8'h55, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b1);
        do_instr(8'd0, 5'd0, 2'd0, 8'd0, 8'd0, 2'd3, 8'd9, 8'd9, 8'd0, 1'b0, 0, 1'b1);
        do_instr(8'd1, 5'd0, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0);

        ack_lat = 5;
        run = 1'b1;
        @(negedge clock);
        check("pre_rst_fetch", state, STATE_FETCH);
        check("pre_rst_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_state", state, STATE_IDLE);
        ack_lat = 0;
        @(negedge clock);
        reset = 1'b0;
        m_pc = 8'd0;
        m_sp = 5'd0;
        @(negedge clock);
        check("post_rst_fetch", state, STATE_FETCH);
        check("post_rst_addr", mem_addr, 8'd0);
        do_instr(8'd1, 5'd3, 2'd3, 8'h11, 8'h22, 2'd1, 8'h30, 8'h5A, 8'd1, 1'b0, 1, 1'b1);

        for (int k = 0; k < 40; k++) begin
            do_instr(8'($urandom), 5'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                     2'($urandom), 8'($urandom), 8'($urandom),
                     ($urandom_range(3) == 0) ? 8'($urandom_range(3, 1)) : 8'd0,
                     ($urandom_range(5) == 0), $urandom_range(2), ($urandom_range(7) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
